// File: rtl/gate_check_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gate_check_pkg
// Purpose : Shared types and constants for the gate response checker: the
//           sweep FSM state encoding and the bit positions of the four gate
//           outputs on the dut_y / expected / mask buses.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package gate_check_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int IDX_AND  = 0;
  localparam int IDX_OR   = 1;
  localparam int IDX_XOR  = 2;
  localparam int IDX_NAND = 3;
  localparam int NUM_OUT  = 4;

endpackage : gate_check_pkg
`default_nettype wire

// File: rtl/gate_golden.sv
`default_nettype none
// ============================================================================
// Module  : gate_golden
// Purpose : Combinational golden model of the gate block under test.
// Ports   : stim     - input vector currently applied to the gate block
//           expected - reference outputs [0]=AND [1]=OR [2]=XOR [3]=NAND
// Revision: 1.0 - initial release
// ============================================================================
module gate_golden
  import gate_check_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0]    stim,
  output logic [NUM_OUT-1:0] expected
);

  always_comb begin
    expected           = '0;
    expected[IDX_AND]  = &stim;
    expected[IDX_OR]   = |stim;
    expected[IDX_XOR]  = ^stim;
    expected[IDX_NAND] = ~&stim;
  end

endmodule : gate_golden
`default_nettype wire

// File: rtl/gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module  : gate_response_checker
// Purpose : On-chip exhaustive sweeper for a 2-input-class gate block. Each
//           vector is driven, allowed to settle, sampled and compared with
//           the golden model; mismatches are counted and the first failing
//           vector and its difference mask are recorded.
// Ports   : clk              - rising-edge clock
//           rst              - asynchronous active-high reset
//           start            - pulse, starts a sweep from IDLE or DONE
//           stim             - vector driven to the gate block
//           dut_y            - gate block outputs [0]=AND [1]=OR [2]=XOR [3]=NAND
//           busy             - sweep in progress
//           done             - sweep finished, held until next start/reset
//           pass             - no mismatches (valid with done)
//           err_count        - number of mismatching vectors
//           first_fail_vec   - vector of the first mismatch
//           first_fail_mask  - dut_y ^ expected at the first mismatch
//           first_fail_valid - a mismatch was recorded this sweep
// Revision: 1.0 - initial release
// ============================================================================
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      stim,
  input  logic [NUM_OUT-1:0]   dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_fail_vec,
  output logic [NUM_OUT-1:0]   first_fail_mask,
  output logic                 first_fail_valid
);

  localparam int              CNT_W       = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [N_IN-1:0]  LAST_VEC    = {N_IN{1'b1}};

  state_t             state;
  state_t             state_nxt;
  logic [N_IN-1:0]    vec;
  logic [CNT_W-1:0]   settle_cnt;
  logic [NUM_OUT-1:0] expected;
  logic [NUM_OUT-1:0] diff;
  logic               mismatch;

  gate_golden #(
    .N_IN (N_IN)
  ) u_golden (
    .stim     (stim),
    .expected (expected)
  );

  assign diff = dut_y ^ expected;

  // Written as "equal clears the flag" so an unknown compare result in
  // simulation falls through to the mismatch default.
  always_comb begin
    mismatch = 1'b1;
    if (dut_y == expected) begin
      mismatch = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        state_nxt = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        // Counter was loaded with SETTLE_CYCLES, so leaving at 1 gives
        // exactly SETTLE_CYCLES cycles in this state.
        if (settle_cnt <= CNT_W'(1)) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        state_nxt = (vec == LAST_VEC) ? DONE : DRIVE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec              <= '0;
      stim             <= '0;
      settle_cnt       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_mask  <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec              <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_mask  <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        DRIVE: begin
          stim       <= vec;
          settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 1'b1;
        end
        SAMPLE: begin
          assert (mismatch == (dut_y !== expected));
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!first_fail_valid) begin
              first_fail_vec   <= stim;
              first_fail_mask  <= diff;
              first_fail_valid <= 1'b1;
            end
          end
          if (vec == LAST_VEC) begin
            busy <= 1'b0;
            done <= 1'b1;
            // Include this final sample, whose increment is not yet visible.
            pass <= (err_count == '0) && !mismatch;
          end else begin
            vec <= vec + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : gate_response_checker
`default_nettype wire
